// File: rtl/mul_pkg.sv
// Shared encodings for the sequential RV32M multiply controller.
package mul_pkg;

  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEGA,
    S_NEGB,
    S_MUL,
    S_FIXLO,
    S_FIXHI,
    S_DONE
  } state_e;

endpackage

// File: rtl/mul_seq_ctrl_cla.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups, group carries rippled.
module cla_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] g, p;
  logic [8:0]  gc;

  assign g     = i_a & i_b;
  assign p     = i_a ^ i_b;
  assign gc[0] = i_cin;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    logic [3:0] gg, pp;
    logic [4:0] cc;
    assign gg    = g[4*k +: 4];
    assign pp    = p[4*k +: 4];
    assign cc[0] = gc[k];
    assign cc[1] = gg[0] | (pp[0] & cc[0]);
    assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
    assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & cc[0]);
    assign cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & cc[0]);
    assign o_sum[4*k +: 4] = pp ^ cc[3:0];
    assign gc[k+1]         = cc[4];
  end

  assign o_cout = gc[8];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential RV32M multiplier: sign-magnitude shift-add sharing one CLA across
// operand negation, 32 iterations and 64-bit product negation.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = MUL_ITER
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_e          state_q, state_d;
  op_e             op_q, op_d, op_in;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, p_hi_q, p_hi_d, p_lo_q, p_lo_d, res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d, carry_q, carry_d;
  logic            neg_p;
  logic [XLEN-1:0] add_a, add_b, sum;
  logic            add_cin, cout;

  assign op_in = op_e'(i_op);
  assign neg_p = neg_a_q ^ neg_b_q;

  cla_32bit u_cla (
    .i_a    (add_a),
    .i_b    (add_b),
    .i_cin  (add_cin),
    .o_sum  (sum),
    .o_cout (cout)
  );

  // Adder operand mux; conditional invert plus carry-in gives two's-complement negate.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      S_NEGA:  begin add_a = neg_a_q ? ~a_q : a_q;       add_cin = neg_a_q; end
      S_NEGB:  begin add_a = neg_b_q ? ~b_q : b_q;       add_cin = neg_b_q; end
      S_MUL:   begin add_a = p_hi_q; add_b = p_lo_q[0] ? a_q : '0;        end
      S_FIXLO: begin add_a = neg_p ? ~p_lo_q : p_lo_q;   add_cin = neg_p;   end
      S_FIXHI: begin add_a = neg_p ? ~p_hi_q : p_hi_q;   add_cin = carry_q; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    carry_d = carry_q;
    unique case (state_q)
      S_IDLE: if (i_start) begin
        op_d    = op_in;
        a_d     = i_rs1;
        b_d     = i_rs2;
        neg_a_d = i_rs1[XLEN-1] & ((op_in == OP_MULH) | (op_in == OP_MULHSU));
        neg_b_d = i_rs2[XLEN-1] & (op_in == OP_MULH);
        state_d = S_NEGA;
      end
      S_NEGA: begin
        a_d     = sum;
        state_d = S_NEGB;
      end
      // |rs2| lands straight in P_lo so MUL starts iterating on its first cycle.
      S_NEGB: begin
        b_d     = sum;
        p_lo_d  = sum;
        p_hi_d  = '0;
        cnt_d   = '0;
        state_d = S_MUL;
      end
      S_MUL: begin
        {p_hi_d, p_lo_d} = {cout, sum, p_lo_q[XLEN-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_FIXLO;
      end
      S_FIXLO: begin
        p_lo_d  = sum;
        carry_d = cout & neg_p;
        state_d = S_FIXHI;
      end
      S_FIXHI: begin
        p_hi_d  = sum;
        res_d   = (op_q == OP_MUL) ? p_lo_q : sum;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      carry_q <= carry_d;
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_DONE);
  assign o_result = res_q;

endmodule
